layer_wb_writer: RTL and testbench
==================================

LAYER_WB_WRITER -- requirements
Module: layer_wb_writer

Interface
REQ-001 Parameter ADDR_W, default 14, width of the RAM store address.
REQ-002 Parameter BASE_ADDR, default 0, first RAM address written after each start.
REQ-003 Parameter NUM_BYTES, default 4096, bytes written per job; must be a nonzero multiple of 4.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 start_write_back  input  1  one-cycle pulse that begins a job.
REQ-007 abort  input  1  synchronous job cancel.
REQ-008 in_valid  input  1  the four result lanes below carry a group.
REQ-009 out0, out1, out2, out3  input  8 each  result bytes for lanes 0-3.
REQ-010 in_ready  output  1  block accepts a group this cycle.
REQ-011 wr_en  output  1  RAM write strobe.
REQ-012 ram_store_addr  output  ADDR_W  RAM write address.
REQ-013 ram_wdata  output  8  RAM write data.
REQ-014 reg_num  output  3  lane index (0-3) of the current write.
REQ-015 busy  output  1  job in progress.
REQ-016 stop_write_back  output  1  one-cycle pulse: job completed.

Function
REQ-017 The FSM SHALL have the states IDLE, LOAD, WRITE and DONE.
REQ-018 IDLE: start_write_back=1 SHALL load addr=BASE_ADDR and remaining=NUM_BYTES, then go to LOAD; busy is 1 in every state except IDLE.
REQ-019 LOAD: in_ready=1; a handshake (in_valid and in_ready both 1) SHALL capture out0-out3 into a 4x8 buffer, set lane=0 and go to WRITE.
REQ-020 in_ready SHALL be 0 in IDLE, WRITE and DONE; in_valid outside LOAD SHALL be ignored and the data dropped.
REQ-021 WRITE: each cycle, wr_en=1, ram_wdata=buffer[lane], reg_num=lane and ram_store_addr=addr; then addr+1, lane+1 and remaining-1.
REQ-022 Latency: a handshake at cycle N SHALL produce lane 0 through lane 3 writes at cycles N+1 through N+4, in that order.
REQ-023 After the lane-3 write, the FSM SHALL go to DONE if remaining has reached 0, else return to LOAD.
REQ-024 DONE: stop_write_back=1 for exactly one cycle, then IDLE.
REQ-025 ram_store_addr SHALL wrap from 2^ADDR_W-1 to 0 with no error indication.
REQ-026 Outside WRITE: wr_en=0; ram_wdata, reg_num and ram_store_addr hold their last values.
REQ-027 start_write_back while busy=1 SHALL be ignored.
REQ-028 abort=1 in LOAD, WRITE or DONE SHALL force IDLE on the next edge.
REQ-029 On abort: no further wr_en, no stop_write_back pulse, and the partial group is discarded.
REQ-030 abort and start_write_back in the same IDLE cycle: abort wins and no job starts.
REQ-031 remaining SHALL be wide enough for NUM_BYTES with no overflow.

Reset
REQ-032 reset=0 SHALL immediately and asynchronously set: state=IDLE, in_ready=0, wr_en=0, ram_store_addr=0, ram_wdata=0, reg_num=0, busy=0, stop_write_back=0, buffer=0, lane=0, remaining=0.
REQ-033 Reset asserted mid-WRITE SHALL cancel the job, with no further writes after reset is released until a new start_write_back.

Verification
REQ-034 NUM_BYTES=8, BASE_ADDR=100; start; groups {1,2,3,4} then {5,6,7,8}, each presented one cycle after in_ready -> writes (100,1) (101,2) (102,3) (103,4) (104,5) (105,6) (106,7) (107,8) with reg_num 0,1,2,3,0,1,2,3; stop_write_back one cycle after the last write; busy=0 afterwards.
REQ-035 Handshake at cycle N with {0xAA,0xBB,0xCC,0xDD} -> wr_en=1 at cycles N+1..N+4 with data AA, BB, CC, DD; in_valid held high during those cycles does not capture.
REQ-036 BASE_ADDR=16382, NUM_BYTES=4 -> write addresses 16382, 16383, 0, 1.
REQ-037 Abort in the cycle after the lane-1 write -> no lane-2 or lane-3 write, no stop_write_back, state IDLE; a new start then writes again from BASE_ADDR.
REQ-038 reset driven low during the lane-2 write -> wr_en=0 and all outputs 0 within the same cycle; start_write_back pulsed during a job -> no effect on the write sequence or the address.

Source files
------------

// File: rtl/layer_wb_writer.sv
// Layer write-back writer: takes 4-byte result groups over a valid/ready handshake
// and streams them byte by byte into RAM from BASE_ADDR, for NUM_BYTES bytes per job.
`timescale 1ns/1ps
module layer_wb_writer #(
  parameter int unsigned ADDR_W    = 14,
  parameter int unsigned BASE_ADDR = 0,
  parameter int unsigned NUM_BYTES = 4096
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start_write_back,
  input  logic              abort,
  input  logic              in_valid,
  input  logic [7:0]        out0,
  input  logic [7:0]        out1,
  input  logic [7:0]        out2,
  input  logic [7:0]        out3,
  output logic              in_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] ram_store_addr,
  output logic [7:0]        ram_wdata,
  output logic [2:0]        reg_num,
  output logic              busy,
  output logic              stop_write_back
);

  localparam int unsigned REM_W = $clog2(NUM_BYTES + 1);

  typedef enum logic [1:0] {IDLE, LOAD, WRITE, DONE} state_e;

  state_e            state_q;
  logic [ADDR_W-1:0] addr_q;
  logic [REM_W-1:0]  rem_q;
  logic [1:0]        lane_q;
  logic [3:0][7:0]   data_q;
  logic              in_ready_q;
  logic              wr_en_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [7:0]        wdata_q;
  logic [2:0]        reg_num_q;
  logic              busy_q;
  logic              stop_q;

  logic [1:0]        lane_nx_c;

  always_comb begin
    lane_nx_c = lane_q + 2'd1;
  end

  // Write outputs are registered one edge ahead: lane_q is the lane on the bus now,
  // addr_q is the next address to issue.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      rem_q      <= '0;
      lane_q     <= '0;
      data_q     <= '0;
      in_ready_q <= 1'b0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wdata_q    <= '0;
      reg_num_q  <= '0;
      busy_q     <= 1'b0;
      stop_q     <= 1'b0;
    end else begin
      wr_en_q <= 1'b0;
      stop_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start_write_back && !abort) begin
            addr_q     <= ADDR_W'(BASE_ADDR);
            rem_q      <= REM_W'(NUM_BYTES);
            in_ready_q <= 1'b1;
            busy_q     <= 1'b1;
            state_q    <= LOAD;
          end
        end
        LOAD: begin
          if (abort) begin
            in_ready_q <= 1'b0;
            busy_q     <= 1'b0;
            state_q    <= IDLE;
          end else if (in_valid) begin
            data_q     <= {out3, out2, out1, out0};
            lane_q     <= 2'd0;
            wr_en_q    <= 1'b1;
            wdata_q    <= out0;
            reg_num_q  <= 3'd0;
            wr_addr_q  <= addr_q;
            addr_q     <= addr_q + ADDR_W'(1);
            rem_q      <= rem_q - REM_W'(1);
            in_ready_q <= 1'b0;
            state_q    <= WRITE;
          end
        end
        WRITE: begin
          if (abort) begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else if (lane_q == 2'd3) begin
            if (rem_q == '0) begin
              stop_q  <= 1'b1;
              state_q <= DONE;
            end else begin
              in_ready_q <= 1'b1;
              state_q    <= LOAD;
            end
          end else begin
            lane_q    <= lane_nx_c;
            wr_en_q   <= 1'b1;
            wdata_q   <= data_q[lane_nx_c];
            reg_num_q <= 3'(lane_nx_c);
            wr_addr_q <= addr_q;
            addr_q    <= addr_q + ADDR_W'(1);
            rem_q     <= rem_q - REM_W'(1);
          end
        end
        DONE: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          in_ready_q <= 1'b0;
          busy_q     <= 1'b0;
          state_q    <= IDLE;
        end
      endcase
    end
  end

  assign in_ready        = in_ready_q;
  assign wr_en           = wr_en_q;
  assign ram_store_addr  = wr_addr_q;
  assign ram_wdata       = wdata_q;
  assign reg_num         = reg_num_q;
  assign busy            = busy_q;
  assign stop_write_back = stop_q;

endmodule

// File: tb/tb_layer_wb_writer.sv
// Bench for layer_wb_writer: two instances (BASE 100 / 8 bytes, BASE 16382 / 4 bytes)
// checked against a write scoreboard holding address, data, lane and cycle.
`timescale 1ns/1ps
module tb_layer_wb_writer;

  localparam int unsigned AW = 14;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [7:0]    d;
    logic [2:0]    r;
    logic [31:0]   c;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start [2];
  logic          abrt  [2];
  logic          vld   [2];
  logic [31:0]   grp   [2];
  logic          rdy   [2];
  logic          wr    [2];
  logic          bsy   [2];
  logic          stp   [2];
  logic [AW-1:0] addr  [2];
  logic [7:0]    wd    [2];
  logic [2:0]    rn    [2];

  exp_t        q0[$];
  exp_t        q1[$];
  int unsigned cyc = 0;
  int unsigned next_a [2];
  int          stop_cnt [2] = '{0, 0};
  int          n_chk = 0;
  int          n_bad = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  layer_wb_writer #(.ADDR_W(AW), .BASE_ADDR(100), .NUM_BYTES(8)) u_dut0 (
    .clk(clk), .reset(rst_n), .start_write_back(start[0]), .abort(abrt[0]),
    .in_valid(vld[0]), .out0(grp[0][7:0]), .out1(grp[0][15:8]),
    .out2(grp[0][23:16]), .out3(grp[0][31:24]), .in_ready(rdy[0]), .wr_en(wr[0]),
    .ram_store_addr(addr[0]), .ram_wdata(wd[0]), .reg_num(rn[0]), .busy(bsy[0]),
    .stop_write_back(stp[0]));

  layer_wb_writer #(.ADDR_W(AW), .BASE_ADDR(16382), .NUM_BYTES(4)) u_dut1 (
    .clk(clk), .reset(rst_n), .start_write_back(start[1]), .abort(abrt[1]),
    .in_valid(vld[1]), .out0(grp[1][7:0]), .out1(grp[1][15:8]),
    .out2(grp[1][23:16]), .out3(grp[1][31:24]), .in_ready(rdy[1]), .wr_en(wr[1]),
    .ram_store_addr(addr[1]), .ram_wdata(wd[1]), .reg_num(rn[1]), .busy(bsy[1]),
    .stop_write_back(stp[1]));

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  task automatic push(input int k, input exp_t e);
    if (k == 0) q0.push_back(e);
    else q1.push_back(e);
  endtask

  task automatic mon_write(input int k);
    exp_t e;
    if ((k == 0 && q0.size() == 0) || (k == 1 && q1.size() == 0)) begin
      check($sformatf("unexpected_wr%0d", k), 32'(addr[k]), 32'hFFFF_FFFF);
      return;
    end
    if (k == 0) e = q0.pop_front();
    else e = q1.pop_front();
    check($sformatf("wr_addr%0d", k), 32'(addr[k]), 32'(e.a));
    check($sformatf("wr_data%0d", k), 32'(wd[k]), 32'(e.d));
    check($sformatf("reg_num%0d", k), 32'(rn[k]), 32'(e.r));
    check($sformatf("wr_cycle%0d", k), cyc, e.c);
  endtask

  // Scoreboard consumer: every write strobe must match the oldest expected write.
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (stp[k]) stop_cnt[k]++;
      if (wr[k]) mon_write(k);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic outs_zero(input int k, input string tag);
    check({tag, "_wr"},   32'(wr[k]),   32'd0);
    check({tag, "_addr"}, 32'(addr[k]), 32'd0);
    check({tag, "_data"}, 32'(wd[k]),   32'd0);
    check({tag, "_reg"},  32'(rn[k]),   32'd0);
    check({tag, "_busy"}, 32'(bsy[k]),  32'd0);
    check({tag, "_rdy"},  32'(rdy[k]),  32'd0);
    check({tag, "_stop"}, 32'(stp[k]),  32'd0);
  endtask

  task automatic do_start(input int k, input int unsigned base);
    tick();
    start[k] = 1'b1;
    tick();
    start[k] = 1'b0;
    next_a[k] = base;
    check($sformatf("busy_after_start%0d", k), 32'(bsy[k]), 32'd1);
  endtask

  // mode: 0 plain, 1 hold in_valid over the writes, 2 abort after lane 1,
  // 3 reset during lane 2, 4 start pulse during the writes
  task automatic send(input int k, input logic [31:0] g, input int mode);
    int unsigned c;
    int          nl;
    int          n;
    exp_t        e;
    n = 0;
    while (!rdy[k] && n < 20) begin
      tick();
      n++;
    end
    check($sformatf("in_ready_wait%0d", k), 32'(rdy[k]), 32'd1);
    tick();
    vld[k] = 1'b1;
    grp[k] = g;
    c = cyc;
    nl = (mode == 2 || mode == 3) ? 2 : 4;
    for (int l = 0; l < nl; l++) begin
      e.a = AW'(next_a[k]);
      e.d = g[8*l +: 8];
      e.r = 3'(l);
      e.c = c + 1 + 32'(l);
      push(k, e);
      next_a[k] = (next_a[k] + 1) % (1 << AW);
    end
    tick();
    if (mode == 1) grp[k] = 32'h1122_3344;
    else vld[k] = 1'b0;
    tick();
    if (mode == 2) abrt[k] = 1'b1;
    if (mode == 4) start[k] = 1'b1;
    tick();
    abrt[k] = 1'b0;
    start[k] = 1'b0;
    if (mode == 2) begin
      check("abort_busy", 32'(bsy[k]), 32'd0);
      check("abort_rdy",  32'(rdy[k]), 32'd0);
      check("abort_wr",   32'(wr[k]),  32'd0);
    end
    if (mode == 3) begin
      #2 rst_n = 1'b0;
      #1 outs_zero(k, "midreset");
      tick();
      rst_n = 1'b1;
    end
    tick();
    tick();
    vld[k] = 1'b0;
  endtask

  task automatic expect_more(input int k);
    check($sformatf("mid_stop%0d", k), 32'(stp[k]), 32'd0);
    check($sformatf("mid_rdy%0d", k),  32'(rdy[k]), 32'd1);
  endtask

  task automatic expect_done(input int k);
    check($sformatf("stop_pulse%0d", k), 32'(stp[k]), 32'd1);
    check($sformatf("stop_busy%0d", k),  32'(bsy[k]), 32'd1);
    tick();
    check($sformatf("stop_end%0d", k),   32'(stp[k]), 32'd0);
    check($sformatf("idle_busy%0d", k),  32'(bsy[k]), 32'd0);
  endtask

  initial begin
    int sc;
    for (int k = 0; k < 2; k++) begin
      start[k] = 1'b0;
      abrt[k]  = 1'b0;
      vld[k]   = 1'b0;
      grp[k]   = '0;
      next_a[k] = 0;
    end
    rst_n = 1'b0;
    repeat (2) tick();
    outs_zero(0, "rst0");
    outs_zero(1, "rst1");
    rst_n = 1'b1;

    // Two-group job into addresses 100..107
    do_start(0, 100);
    send(0, 32'h0403_0201, 0);
    expect_more(0);
    send(0, 32'h0807_0605, 0);
    expect_done(0);

    // Wrapping job with in_valid held high through the writes
    do_start(1, 16382);
    send(1, 32'hDDCC_BBAA, 1);
    expect_done(1);

    // Abort after lane 1, then a fresh job restarts from BASE_ADDR
    sc = stop_cnt[0];
    do_start(0, 100);
    send(0, 32'h2423_2221, 2);
    repeat (3) tick();
    check("abort_no_stop", 32'(stop_cnt[0]), 32'(sc));
    check("abort_still_idle", 32'(bsy[0]), 32'd0);
    do_start(0, 100);
    send(0, 32'h3433_3231, 0);
    expect_more(0);
    send(0, 32'h3837_3635, 0);
    expect_done(0);

    // in_valid while idle is dropped; abort beats a same-cycle start
    vld[1] = 1'b1;
    grp[1] = 32'hEEEE_EEEE;
    repeat (3) tick();
    vld[1] = 1'b0;
    start[1] = 1'b1;
    abrt[1]  = 1'b1;
    tick();
    start[1] = 1'b0;
    abrt[1]  = 1'b0;
    check("abort_start_busy", 32'(bsy[1]), 32'd0);
    check("abort_start_rdy",  32'(rdy[1]), 32'd0);
    repeat (2) tick();

    // A start pulse during the writes must not disturb the sequence
    do_start(1, 16382);
    send(1, 32'h5453_5251, 4);
    expect_done(1);

    // Reset during lane 2, then a clean job
    do_start(0, 100);
    send(0, 32'h6463_6261, 3);
    repeat (3) tick();
    check("post_reset_busy", 32'(bsy[0]), 32'd0);
    do_start(0, 100);
    send(0, 32'h7473_7271, 0);
    expect_more(0);
    send(0, 32'h7877_7675, 0);
    expect_done(0);

    repeat (4) tick();
    check("sb_empty0", 32'(q0.size()), 32'd0);
    check("sb_empty1", 32'(q1.size()), 32'd0);
    check("stops0", 32'(stop_cnt[0]), 32'd3);
    check("stops1", 32'(stop_cnt[1]), 32'd2);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
